// File: rtl/regfile_pkg.sv
// Shared widths, typedefs and helpers for the multi-port register file.
// Optional build macro used by this slice: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_NUM_DEF = 32;
  localparam int PEND_W_DEF  = 2;

  // Address width for n registers; never below one bit.
  function automatic int aw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int AW_DEF   = aw_of(REG_NUM_DEF);
  localparam int PEND_MAX = (1 << PEND_W_DEF) - 1;

  typedef logic [AW_DEF-1:0]     rf_addr_t;
  typedef logic [DATA_W_DEF-1:0] rf_data_t;

endpackage

// File: rtl/regfile_sb_ctr.sv
// Pending-producer scoreboard: one saturating up/down counter per register plus
// the iss_full and rd_busy views of it. Honours REGFILE_BYPASS_EN for rd_busy.
module regfile_sb_ctr
  import regfile_pkg::*;
#(
  parameter  int REG_NUM = REG_NUM_DEF,
  parameter  int NRD     = 2,
  parameter  int NWR     = 1,
  parameter  int PEND_W  = PEND_W_DEF,
  localparam int AW      = aw_of(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_full
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0]  cnt_reg  [REG_NUM];
  logic [PEND_W-1:0]  cnt_next [REG_NUM];
  logic [REG_NUM-1:0] wr_hit;

  assign iss_full = iss_en && (iss_addr != '0) && (cnt_reg[iss_addr] == CNT_MAX);

  genvar gi, gw;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
      logic [NWR-1:0] port_hit;
      logic           inc;
      for (gw = 0; gw < NWR; gw++) begin : g_port
        assign port_hit[gw] = wr_en[gw] && (wr_addr[gw*AW +: AW] == AW'(gi));
      end
      // Any number of hitting write ports retires exactly one producer.
      assign wr_hit[gi] = |port_hit;
      assign inc = iss_en && !iss_full && (iss_addr == AW'(gi)) && (gi != 0);
      assign cnt_next[gi] =
          (inc && !wr_hit[gi])                          ? cnt_reg[gi] + CNT_ONE :
          (!inc && wr_hit[gi] && (cnt_reg[gi] != '0))   ? cnt_reg[gi] - CNT_ONE :
                                                          cnt_reg[gi];
    end

    for (gi = 0; gi < NRD; gi++) begin : g_busy
      logic [AW-1:0]     a;
      logic [PEND_W-1:0] c;
      assign a = rd_addr[gi*AW +: AW];
      assign c = cnt_reg[a];
`ifdef REGFILE_BYPASS_EN
      // A forwarded write already satisfies one producer.
      assign rd_busy[gi] = rd_en[gi] && (a != '0) && (wr_hit[a] ? (c > CNT_ONE) : (c != '0));
`else
      assign rd_busy[gi] = rd_en[gi] && (a != '0) && (c != '0);
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) cnt_reg[r] <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) cnt_reg[r] <= cnt_next[r];
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with pending-write scoreboard; x0 reads as zero.
// REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int REG_NUM = REG_NUM_DEF,
  parameter  int NRD     = 2,
  parameter  int NWR     = 1,
  parameter  int PEND_W  = PEND_W_DEF,
  localparam int AW      = aw_of(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic                  iss_full
);

  logic [DATA_W-1:0] mem_reg [REG_NUM];

  // Ascending port loop: the last non-blocking assignment, highest port, wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) mem_reg[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0))
          mem_reg[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_W +: DATA_W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]     a;
      logic [DATA_W-1:0] val;
      assign a = rd_addr[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      always_comb begin
        val = mem_reg[a];
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == a))
            val = wr_data[w*DATA_W +: DATA_W];
        end
      end
`else
      assign val = mem_reg[a];
`endif
      assign rd_data[gi*DATA_W +: DATA_W] = (rd_en[gi] && (a != '0)) ? val : '0;
    end
  endgenerate

  regfile_sb_ctr #(
    .REG_NUM (REG_NUM),
    .NRD     (NRD),
    .NWR     (NWR),
    .PEND_W  (PEND_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_full (iss_full)
  );

endmodule
